phy_tx_stim_gen: RTL and testbench
==================================

# phy_tx_stim_gen

Synthesizable, parametrised stimulus generator for the `phy_tx` path. It runs entirely on `clk_32f` and produces:
- clock-enable strobes at the f/2f/4f rates;
- a serial control stream of COM (8'hBC) words followed by IDL (8'h7C) words;
- a finite multi-lane data burst with per-lane valid.

It replaces free-running simulation-only stimulus, so the same pattern can drive `phy_tx` both in benches and on hardware.

## Interface
Parameters:
- `LANES`, 4: number of data lanes.
- `WIDTH`, 8: data width per lane.
- `DIV`, 32: `clk_32f` cycles per f period. Must be a power of 2 and ≥ 8.
- `COM_WORDS`, 4: COM words per sequence.
- `IDL_WORDS`, 12: IDL words per sequence.
- `BURST`, 2: data words per lane per sequence. Must satisfy 1 ≤ `BURST` ≤ `IDL_WORDS*8/DIV`.
- `STEP`, 8'h11: decrement step for descending mode.

Ports:
- `clk_32f` in 1: the only clock.
- `reset_L` in 1: synchronous, active-low reset.
- `start` in 1: level-sampled; starts a sequence when in IDLE.
- `mode` in 1: 0 = counting pattern, 1 = descending pattern. Sampled at start.
- `en_f`, `en_2f`, `en_4f` out 1: single-cycle strobes every `DIV`, `DIV/2` and `DIV/4` cycles.
- `ctrl_bit` out 1: serial control stream, MSB first.
- `ctrl_sync` out 1: high on the first bit of each control word.
- `data_out` out `LANES*WIDTH`: lane i occupies bits [i*WIDTH +: WIDTH].
- `valid` out `LANES`: per-lane valid.
- `busy` out 1: high in COM and IDL.
- `done` out 1: one-cycle pulse at the end of a sequence.

## Operation
- **Divider:** a free-running counter `cnt`, 0..`DIV`-1, reset to 0.
  - `en_f` = (`cnt`==`DIV`-1).
  - `en_2f` = (`cnt`[log2(`DIV`)-2:0] all ones).
  - `en_4f` = (`cnt`[log2(`DIV`)-3:0] all ones).
- **FSM states:** IDLE → COM → IDL → DONE → IDLE.
  - IDLE: `start`=1 → COM. The mode is latched in this transition.
  - COM: shifts 8'hBC `COM_WORDS` times, one bit per cycle, then → IDL.
  - IDL: shifts 8'h7C `IDL_WORDS` times, then → DONE.
  - DONE: lasts 1 cycle with `done`=1, then → IDLE.
- **Control stream:**
  - A 3-bit bit counter and a word counter (sized for max(`COM_WORDS`, `IDL_WORDS`)) sequence the words.
  - `ctrl_bit`=0 and `ctrl_sync`=0 outside COM/IDL.
- **Data generator:**
  - Active only in IDL. On each `en_f` while in IDL and word index k < `BURST`, all lanes present word k and `valid`=all ones.
  - Word k, lane i, with n = k*`LANES`+i:
    - mode 0: n mod 2^`WIDTH`;
    - mode 1: (2^`WIDTH`-1) − `STEP`*n mod 2^`WIDTH`.
  - On the first `en_f` after k reaches `BURST`: `valid`=0 and `data_out`=0.
  - On leaving IDL: `valid`=0 and `data_out`=0.
- **Start while busy:** `start` is ignored in COM, IDL and DONE.
- **Reset values** (on the edge where `reset_L`=0, including mid-sequence):
  - `cnt`=0, state IDLE, all counters 0;
  - `ctrl_bit`=0, `ctrl_sync`=0, `data_out`=0, `valid`=0, `busy`=0, `done`=0;
  - `en_*`=0.

## Timing
- **All outputs are registered.**
- **Control start:** `start` sampled high in IDLE at edge t:
  - the first COM bit (1) and `ctrl_sync`=1 appear after edge t+1;
  - `busy` rises at the same time.
- **Sequence length:** COM occupies 8*`COM_WORDS` cycles, then IDL 8*`IDL_WORDS` cycles.
  - `done` is high for exactly 1 cycle immediately after the last IDL bit.
  - `busy` falls in that same cycle.
- **Strobe phase:** strobes are independent of the FSM.
  - After reset release, `en_4f` first rises after `DIV/4` edges, `en_2f` after `DIV/2`, `en_f` after `DIV`.
- **Data latency:** data/valid update on the edge following the cycle in which `en_f`=1. They are held for `DIV` cycles.
- **Sequence end during a burst:** if IDL ends before `BURST` words have been issued, the data is cleared with DONE. This cannot happen with legal parameters, and the bench asserts it never occurs.

## Structure
- **Package `phy_pkg`:**
  - constants COM=8'hBC and IDL=8'h7C;
  - the state enum {IDLE, COM, IDL, DONE};
  - the mode enum.
- **Sub-module `clk_en_div`:** the divider counter and the three strobes, parametrised by `DIV`. The top level contains the FSM, serializer and data generator.

## Test plan
1. **Reset:** hold `reset_L`=0 for 3 cycles → all outputs 0. After release, `en_4f` pulses every 8 cycles, `en_2f` every 16, `en_f` every 32 (defaults).
2. **Control stream:** `start` pulse with defaults → `ctrl_bit` is 10111100 ×4, then 01111100 ×12 (128 cycles). `ctrl_sync` is high every 8th cycle, then `done` pulses once and `busy`=0.
3. **Descending data (mode=1):**
   - lanes 0..3 are FF,EE,DD,CC for one f period;
   - then BB,AA,99,88;
   - then `valid`=0 and data 0.
4. **Counting data (mode=0), `LANES`=2, `WIDTH`=16, `BURST`=3:** words are (0,1), (2,3), (4,5), then `valid`=0.
5. **Start while busy:** `start` held high through the whole sequence → exactly one sequence runs. A new sequence begins the cycle after DONE→IDLE.
6. **Reset mid-operation:** `reset_L`=0 in the middle of IDL with `valid`=1 → all outputs 0 on the next edge. After release, `start` restarts cleanly from the first COM bit.

Source files
------------

// File: rtl/phy_tx_stim_gen_pkg.sv
// Shared constants and types for the phy_tx stimulus generator.
package phy_pkg;

   // Control-stream characters
   localparam logic [7:0] COM_CHAR = 8'hBC;
   localparam logic [7:0] IDL_CHAR = 8'h7C;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_COM  = 2'd1,
      S_IDL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef enum logic {
      MODE_COUNT = 1'b0,
      MODE_DESC  = 1'b1
   } mode_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/phy_tx_stim_gen_clk_en_div.sv
// Free-running divider producing registered f/2f/4f clock-enable strobes.
module clk_en_div #(
   parameter int unsigned DIV = 32
) (
   input  logic clk_32f,
   input  logic reset_L,
   output logic en_f,
   output logic en_2f,
   output logic en_4f
);

   localparam int unsigned CW = $clog2(DIV);

   logic [CW-1:0] cnt;

   // Counter wraps naturally at DIV (power of 2); strobes decode the pre-increment value
   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         cnt   <= '0;
         en_f  <= 1'b0;
         en_2f <= 1'b0;
         en_4f <= 1'b0;
      end else begin
         cnt   <= cnt + 1'b1;
         en_f  <= &cnt;
         en_2f <= &cnt[CW-2:0];
         en_4f <= &cnt[CW-3:0];
      end
   end

endmodule

// File: rtl/phy_tx_stim_gen.sv
// Stimulus generator for phy_tx: strobes, COM/IDL control stream and a
// finite multi-lane data burst, all on clk_32f with registered outputs.
module phy_tx_stim_gen
   import phy_pkg::*;
#(
   parameter int unsigned LANES     = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV       = 32,
   parameter int unsigned COM_WORDS = 4,
   parameter int unsigned IDL_WORDS = 12,
   parameter int unsigned BURST     = 2,
   parameter int unsigned STEP      = 'h11
) (
   input  logic                     clk_32f,
   input  logic                     reset_L,
   input  logic                     start,
   input  logic                     mode,
   output logic                     en_f,
   output logic                     en_2f,
   output logic                     en_4f,
   output logic                     ctrl_bit,
   output logic                     ctrl_sync,
   output logic [LANES*WIDTH-1:0]   data_out,
   output logic [LANES-1:0]         valid,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned WC_W = max_u($clog2(max_u(COM_WORDS, IDL_WORDS)), 1);
   localparam int unsigned K_W  = $clog2(BURST + 1);

   localparam logic [WC_W-1:0]  COM_LAST = WC_W'(COM_WORDS - 1);
   localparam logic [WC_W-1:0]  IDL_LAST = WC_W'(IDL_WORDS - 1);
   localparam logic [K_W-1:0]   K_MAX    = K_W'(BURST);
   localparam logic [WIDTH-1:0] ALL1     = '1;
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

   state_t                   state;
   state_t                   state_nxt;
   mode_t                    mode_q;
   logic [2:0]               bit_cnt;
   logic [WC_W-1:0]          word_cnt;
   logic [K_W-1:0]           k_cnt;
   logic                     last_bit;
   logic [WIDTH-1:0]         lane_n;
   logic [LANES*WIDTH-1:0]   burst_word;

   clk_en_div #(
      .DIV(DIV)
   ) u_div (
      .clk_32f (clk_32f),
      .reset_L (reset_L),
      .en_f    (en_f),
      .en_2f   (en_2f),
      .en_4f   (en_4f)
   );

   assign last_bit = (bit_cnt == 3'd7);

   // Next-state logic: word counter end in COM/IDL drives the transitions
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_COM;
         S_COM:  if (last_bit && (word_cnt == COM_LAST)) state_nxt = S_IDL;
         S_IDL:  if (last_bit && (word_cnt == IDL_LAST)) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register; mode is captured on the IDLE->COM transition only
   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         state  <= S_IDLE;
         mode_q <= MODE_COUNT;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE) && start) mode_q <= mode_t'(mode);
      end
   end

   // Bit/word sequencing while shifting; word count restarts at each phase change
   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         bit_cnt  <= '0;
         word_cnt <= '0;
      end else if ((state == S_COM) || (state == S_IDL)) begin
         bit_cnt <= bit_cnt + 3'd1;
         if (last_bit) begin
            if (state_nxt != state) word_cnt <= '0;
            else                    word_cnt <= word_cnt + 1'b1;
         end
      end else begin
         bit_cnt  <= '0;
         word_cnt <= '0;
      end
   end

   // Serializer and status outputs, registered one cycle behind the state
   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         ctrl_bit  <= 1'b0;
         ctrl_sync <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         ctrl_bit  <= 1'b0;
         ctrl_sync <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         case (state)
            S_COM: begin
               ctrl_bit  <= COM_CHAR[~bit_cnt];
               ctrl_sync <= (bit_cnt == 3'd0);
               busy      <= 1'b1;
            end
            S_IDL: begin
               ctrl_bit  <= IDL_CHAR[~bit_cnt];
               ctrl_sync <= (bit_cnt == 3'd0);
               busy      <= 1'b1;
            end
            S_DONE:  done <= 1'b1;
            default: ;
         endcase
      end
   end

   // Word k for every lane: n = k*LANES + i, counting or descending by STEP
   always_comb begin
      burst_word = '0;
      lane_n     = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_n = WIDTH'(32'(k_cnt) * LANES + i);
         if (mode_q == MODE_DESC) burst_word[i*WIDTH +: WIDTH] = ALL1 - STEP_W * lane_n;
         else                     burst_word[i*WIDTH +: WIDTH] = lane_n;
      end
   end

   // Data burst: one word per f period while in IDL, cleared after BURST words or on leaving IDL
   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         data_out <= '0;
         valid    <= '0;
         k_cnt    <= '0;
      end else if (state != S_IDL) begin
         data_out <= '0;
         valid    <= '0;
         k_cnt    <= '0;
      end else if (en_f) begin
         if (k_cnt < K_MAX) begin
            data_out <= burst_word;
            valid    <= '1;
            k_cnt    <= k_cnt + 1'b1;
         end else begin
            data_out <= '0;
            valid    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_phy_tx_stim_gen.sv
// Directed bench for phy_tx_stim_gen: default instance plus a 2-lane/16-bit/3-word instance.
module tb_phy_tx_stim_gen;

   logic clk_32f = 1'b0;
   always #5 clk_32f = ~clk_32f;

   logic reset_L, start_a, start_b, mode;

   logic a_en_f, a_en_2f, a_en_4f, a_bit, a_sync, a_busy, a_done;
   logic [31:0] a_data;
   logic [3:0]  a_valid;
   logic b_en_f, b_en_2f, b_en_4f, b_bit, b_sync, b_busy, b_done;
   logic [31:0] b_data;
   logic [1:0]  b_valid;

   phy_tx_stim_gen u_a (
      .clk_32f(clk_32f), .reset_L(reset_L), .start(start_a), .mode(mode),
      .en_f(a_en_f), .en_2f(a_en_2f), .en_4f(a_en_4f),
      .ctrl_bit(a_bit), .ctrl_sync(a_sync),
      .data_out(a_data), .valid(a_valid), .busy(a_busy), .done(a_done)
   );

   phy_tx_stim_gen #(
      .LANES(2), .WIDTH(16), .BURST(3)
   ) u_b (
      .clk_32f(clk_32f), .reset_L(reset_L), .start(start_b), .mode(mode),
      .en_f(b_en_f), .en_2f(b_en_2f), .en_4f(b_en_4f),
      .ctrl_bit(b_bit), .ctrl_sync(b_sync),
      .data_out(b_data), .valid(b_valid), .busy(b_busy), .done(b_done)
   );

   int total = 0;
   int bad   = 0;
   int ec    = 0;   // edges since reset release
   int sel   = 0;

   always @(posedge clk_32f) ec <= reset_L ? ec + 1 : 0;

   logic [35:0] o_dv;
   logic        o_bit, o_sync, o_busy, o_done;

   always_comb begin
      if (sel == 0) begin
         o_dv = {a_valid, a_data};
         o_bit = a_bit; o_sync = a_sync; o_busy = a_busy; o_done = a_done;
      end else begin
         o_dv = {2'b00, b_valid, b_data};
         o_bit = b_bit; o_sync = b_sync; o_busy = b_busy; o_done = b_done;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Hand-computed burst words {valid, data}; lane 0 in the low bits
   function automatic logic [35:0] exp_word(input int s, input logic m, input int k);
      logic [35:0] w;
      w = '0;
      if (s == 0 && !m) begin
         if (k == 0) w = 36'hF_03020100;
         if (k == 1) w = 36'hF_07060504;
      end else if (s == 0) begin
         if (k == 0) w = 36'hF_CCDDEEFF;
         if (k == 1) w = 36'hF_8899AABB;
      end else begin
         if (k == 0) w = 36'h3_00010000;
         if (k == 1) w = 36'h3_00030002;
         if (k == 2) w = 36'h3_00050004;
      end
      return w;
   endfunction

   task automatic run_seq(input int s, input logic m, input bit hold);
      int t, k, seen, e;
      logic [7:0]  sh_bit, sh_sync, sh_busy;
      logic [35:0] exp_dv, prev_dv;
      sel = s;
      mode = m;
      if (s == 0) start_a = 1'b1; else start_b = 1'b1;
      @(negedge clk_32f);
      t = ec;
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      k = 0; seen = 0; exp_dv = '0; prev_dv = '0;
      sh_bit = '0; sh_sync = '0; sh_busy = '0;
      for (int i = 1; i <= 129; i++) begin
         @(negedge clk_32f);
         e = ec;
         if (e >= t + 33 && e <= t + 128) begin
            if (e >= 33 && ((e - 1) % 32) == 0) begin
               exp_dv = exp_word(s, m, k);
               k++;
            end
         end else begin
            exp_dv = '0;
         end
         chk("data", o_dv, exp_dv);
         if (o_dv[35:32] != 4'd0 && o_dv != prev_dv) seen++;
         prev_dv = o_dv;
         if (i <= 128) begin
            sh_bit  = {sh_bit[6:0], o_bit};
            sh_sync = {sh_sync[6:0], o_sync};
            sh_busy = {sh_busy[6:0], o_busy};
            if ((i % 8) == 0) begin
               if (i <= 32) chk("com_word", sh_bit, 8'hBC);
               else         chk("idl_word", sh_bit, 8'h7C);
               chk("sync", sh_sync, 8'h80);
               chk("busy", sh_busy, 8'hFF);
            end
         end else begin
            chk("done", {o_done, o_busy, o_bit, o_sync}, 4'b1000);
         end
      end
      chk("burst_words", seen, (s == 0) ? 2 : 3);
      @(negedge clk_32f);
      chk("idle_after", {o_done, o_busy}, 2'b00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got_v;
      reset_L = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 1'b0;

      // Reset state and strobe cadence
      repeat (3) @(negedge clk_32f);
      chk("reset_a", {a_en_f, a_en_2f, a_en_4f, a_bit, a_sync, a_busy, a_done, a_valid, a_data}, '0);
      chk("reset_b", {b_en_f, b_en_2f, b_en_4f, b_bit, b_sync, b_busy, b_done, b_valid, b_data}, '0);
      reset_L = 1'b1;
      for (int j = 1; j <= 64; j++) begin
         @(negedge clk_32f);
         chk("strobes", {a_en_f, a_en_2f, a_en_4f}, {(j % 32) == 0, (j % 16) == 0, (j % 8) == 0});
      end

      // Control stream with counting data, then descending data
      run_seq(0, 1'b0, 1'b0);
      run_seq(0, 1'b1, 1'b0);

      // Two lanes, 16 bits, three-word burst
      run_seq(1, 1'b0, 1'b0);

      // Start held high: one sequence, restart right after DONE->IDLE
      run_seq(0, 1'b1, 1'b1);
      @(negedge clk_32f);
      chk("restart", {o_busy, o_sync, o_bit}, 3'b111);
      start_a = 1'b0;

      // Reset in the middle of a burst
      got_v = 1'b0;
      for (int i = 0; i < 200 && !got_v; i++) begin
         @(negedge clk_32f);
         if (a_valid != 4'd0) got_v = 1'b1;
      end
      chk("wait_valid", got_v, 1'b1);
      reset_L = 1'b0;
      @(negedge clk_32f);
      chk("mid_reset", {a_en_f, a_en_2f, a_en_4f, a_bit, a_sync, a_busy, a_done, a_valid, a_data}, '0);
      @(negedge clk_32f);
      reset_L = 1'b1;
      run_seq(0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
